// File: rtl/stream_pkg.sv
// Shared types and defaults for the stream round-robin scheduler and the transmit mux.
// The optional early-release feature is enabled with STREAM_RR_EARLY_RELEASE_EN.
package stream_pkg;

  localparam int NUM_STREAMS_DEF  = 8;
  localparam int DWELL_CYCLES_DEF = 385;

  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_e;

  // Idle select code: only the MSB of the select word is set.
  function automatic int idle_sel(input int sel_w);
    return 1 << (sel_w - 1);
  endfunction

endpackage

// File: rtl/stream_rr_scheduler_if.sv
// Handshake bundle between the stream-enable register, the scheduler and the transmit mux.
interface stream_rr_scheduler_if
  import stream_pkg::*;
#(
  parameter int NUM_STREAMS = NUM_STREAMS_DEF,
  parameter int SEL_W       = $clog2(NUM_STREAMS) + 1
);

  logic                   bt_state;
  logic [NUM_STREAMS-1:0] open_streams;
  logic                   tx_done;
  logic [SEL_W-1:0]       next_sel;
  logic                   slot_start;
  logic                   busy;

  modport master (
    input  bt_state,
    input  open_streams,
    input  tx_done,
    output next_sel,
    output slot_start,
    output busy
  );

  modport slave (
    output bt_state,
    output open_streams,
    output tx_done,
    input  next_sel,
    input  slot_start,
    input  busy
  );

endinterface

// File: rtl/rr_next_open.sv
// Circular priority finder: first set bit of mask starting at ptr+1, with ptr itself tried last.
module rr_next_open #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] ptr,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  always_comb begin : search
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    found    = 1'b0;
    idx      = ptr;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IDX_W'(cand);
      if (!found && mask[cand_idx]) begin
        found = 1'b1;
        idx   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/stream_rr_scheduler.sv
// Round-robin stream scheduler driving the Bluetooth UART transmit mux select.
// Optional macro STREAM_RR_EARLY_RELEASE_EN lets tx_done end a slot early.
//
// state | meaning
// IDLE  | link down or no open stream; next_sel = IDLE_SEL, busy = 0
// DWELL | a stream holds the mux; timer counts cycles of the current slot
module stream_rr_scheduler
  import stream_pkg::*;
#(
  parameter int NUM_STREAMS  = NUM_STREAMS_DEF,
  parameter int SEL_W        = $clog2(NUM_STREAMS) + 1,
  parameter int DWELL_CYCLES = DWELL_CYCLES_DEF,
  parameter int TIMER_W      = 10
) (
  input logic                  clock,
  input logic                  resetn,
  stream_rr_scheduler_if.master sif
);

  localparam int                IDX_W    = SEL_W - 1;
  localparam logic [SEL_W-1:0]  IDLE_SEL = SEL_W'(idle_sel(SEL_W));
  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(DWELL_CYCLES - 1);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_d;
  logic [SEL_W-1:0]   next_sel_q;
  logic               slot_start_q;
  logic               busy_q;
  logic               rel_q;

  logic               found;
  logic [IDX_W-1:0]   found_idx;
  logic               rel_set;
  logic               slot_end;

  rr_next_open #(
    .N     (NUM_STREAMS),
    .IDX_W (IDX_W)
  ) u_next_open (
    .mask  (sif.open_streams),
    .ptr   (ptr_q),
    .found (found),
    .idx   (found_idx)
  );

`ifdef STREAM_RR_EARLY_RELEASE_EN
  // tx_done is only honoured once the slot has run at least one cycle.
  assign rel_set = sif.tx_done && (timer_q != '0);
`else
  logic unused_tx_done;
  assign unused_tx_done = sif.tx_done;
  assign rel_set        = 1'b0;
`endif

  assign timer_d  = timer_q + TIMER_W'(1);
  assign slot_end = !sif.open_streams[ptr_q] || (timer_q == LAST_TICK) || rel_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      ptr_q        <= IDX_W'(NUM_STREAMS - 1);
      timer_q      <= '0;
      next_sel_q   <= IDLE_SEL;
      slot_start_q <= 1'b0;
      busy_q       <= 1'b0;
      rel_q        <= 1'b0;
    end else begin
      slot_start_q <= 1'b0;
      rel_q        <= 1'b0;
      if (!sif.bt_state) begin
        // ptr is kept so the rotation resumes fairly after reconnect.
        state_q    <= IDLE;
        timer_q    <= '0;
        next_sel_q <= IDLE_SEL;
        busy_q     <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            timer_q <= '0;
            if (found) begin
              state_q      <= DWELL;
              ptr_q        <= found_idx;
              next_sel_q   <= {1'b0, found_idx};
              slot_start_q <= 1'b1;
              busy_q       <= 1'b1;
            end else begin
              next_sel_q <= IDLE_SEL;
              busy_q     <= 1'b0;
            end
          end
          DWELL: begin
            if (slot_end) begin
              timer_q <= '0;
              if (found) begin
                ptr_q        <= found_idx;
                next_sel_q   <= {1'b0, found_idx};
                slot_start_q <= 1'b1;
                busy_q       <= 1'b1;
              end else begin
                state_q    <= IDLE;
                next_sel_q <= IDLE_SEL;
                busy_q     <= 1'b0;
              end
            end else begin
              timer_q <= timer_d;
              rel_q   <= rel_q | rel_set;
            end
          end
          default: begin
            state_q    <= IDLE;
            timer_q    <= '0;
            next_sel_q <= IDLE_SEL;
            busy_q     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sif.next_sel   = next_sel_q;
  assign sif.slot_start = slot_start_q;
  assign sif.busy       = busy_q;

endmodule

// File: tb/tb_stream_rr_scheduler.sv
// Directed self-checking bench: an 8-stream/385-cycle instance and a 16-stream/4-cycle instance.
module tb_stream_rr_scheduler;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [3:0] IDLE8  = 4'b1000;
  localparam logic [4:0] IDLE16 = 5'b10000;

  stream_rr_scheduler_if #(.NUM_STREAMS(8))  if8 ();
  stream_rr_scheduler_if #(.NUM_STREAMS(16)) if16 ();

  stream_rr_scheduler #(
    .NUM_STREAMS(8), .DWELL_CYCLES(385), .TIMER_W(10)
  ) u_dut8 (
    .clock (clock),
    .resetn(resetn),
    .sif   (if8)
  );

  stream_rr_scheduler #(
    .NUM_STREAMS(16), .DWELL_CYCLES(4), .TIMER_W(3)
  ) u_dut16 (
    .clock (clock),
    .resetn(resetn),
    .sif   (if16)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    if8.bt_state      = 1'b1;
    if8.open_streams  = 8'b0000_0101;
    if8.tx_done       = 1'b0;
    if16.bt_state     = 1'b0;
    if16.open_streams = '0;
    if16.tx_done      = 1'b0;
    resetn = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (if8.next_sel !== IDLE8) begin
      failures++; $display("FAIL reset_sel8 got=%b want=%b", if8.next_sel, IDLE8);
    end
    checks++;
    if (if8.slot_start !== 1'b0 || if8.busy !== 1'b0) begin
      failures++; $display("FAIL reset_flags8 got=%b%b want=00", if8.slot_start, if8.busy);
    end
    checks++;
    if (if16.next_sel !== IDLE16 || if16.busy !== 1'b0) begin
      failures++; $display("FAIL reset_sel16 got=%b busy=%b want=%b busy=0", if16.next_sel, if16.busy, IDLE16);
    end
  endtask

  task automatic test_round_robin();
    int   exp_seq[3] = '{0, 2, 0};
    int   hold;
    int   pulses;
    logic first;
    resetn = 1'b1;
    tick();
    for (int s = 0; s < 3; s++) begin
      hold   = 0;
      pulses = 0;
      first  = if8.slot_start;
      for (int i = 0; i < 385; i++) begin
        if (if8.next_sel == 4'(exp_seq[s]) && if8.busy) hold++;
        if (if8.slot_start) pulses++;
        tick();
      end
      checks++;
      if (hold !== 385) begin
        failures++; $display("FAIL rr_hold slot=%0d stream=%0d got=%0d want=385", s, exp_seq[s], hold);
      end
      checks++;
      if (pulses !== 1) begin
        failures++; $display("FAIL rr_pulses slot=%0d got=%0d want=1", s, pulses);
      end
      checks++;
      if (first !== 1'b1) begin
        failures++; $display("FAIL rr_first_pulse slot=%0d got=%b want=1", s, first);
      end
    end
    checks++;
    if (if8.next_sel !== 4'd2 || if8.slot_start !== 1'b1) begin
      failures++; $display("FAIL rr_fourth sel got=%0d ss=%b want=2 ss=1", if8.next_sel, if8.slot_start);
    end
  endtask

  task automatic test_single_stream();
    int hold      = 0;
    int pulses    = 0;
    int pulse2    = -1;
    int busy_low  = 0;
    if8.open_streams = 8'b1000_0000;
    tick();
    for (int i = 0; i < 770; i++) begin
      if (if8.next_sel == 4'd7) hold++;
      if (!if8.busy) busy_low++;
      if (if8.slot_start) begin
        pulses++;
        if (i > 0 && pulse2 < 0) pulse2 = i;
      end
      tick();
    end
    checks++;
    if (hold !== 770) begin
      failures++; $display("FAIL single_hold got=%0d want=770", hold);
    end
    checks++;
    if (pulses !== 2 || pulse2 !== 385) begin
      failures++; $display("FAIL single_repulse got=%0d at=%0d want=2 at=385", pulses, pulse2);
    end
    checks++;
    if (busy_low !== 0) begin
      failures++; $display("FAIL single_busy_drop got=%0d want=0", busy_low);
    end
  endtask

  task automatic test_close_mid_slot();
    int pos = -1;
    if8.open_streams = 8'b0010_0100;
    tick();
    checks++;
    if (if8.next_sel !== 4'd2 || if8.slot_start !== 1'b1) begin
      failures++; $display("FAIL close_enter2 got=%0d ss=%b want=2 ss=1", if8.next_sel, if8.slot_start);
    end
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (if8.next_sel !== 4'd2) begin
      failures++; $display("FAIL close_hold2 got=%0d want=2", if8.next_sel);
    end
    if8.open_streams = 8'b0010_0000;
    tick();
    checks++;
    if (if8.next_sel !== 4'd5 || if8.slot_start !== 1'b1) begin
      failures++; $display("FAIL close_switch got=%0d ss=%b want=5 ss=1", if8.next_sel, if8.slot_start);
    end
    for (int i = 1; i <= 400 && pos < 0; i++) begin
      tick();
      if (if8.slot_start) pos = i;
    end
    checks++;
    if (pos !== 385) begin
      failures++; $display("FAIL close_timer_restart got=%0d want=385", pos);
    end
  endtask

  task automatic test_link_drop();
    int idle_ok = 0;
    if8.open_streams = 8'b0000_1000;
    tick();
    checks++;
    if (if8.next_sel !== 4'd3) begin
      failures++; $display("FAIL drop_enter3 got=%0d want=3", if8.next_sel);
    end
    for (int i = 0; i < 10; i++) tick();
    if8.bt_state = 1'b0;
    tick();
    checks++;
    if (if8.next_sel !== IDLE8 || if8.busy !== 1'b0 || if8.slot_start !== 1'b0) begin
      failures++; $display("FAIL drop_idle got=%b busy=%b ss=%b want=%b busy=0 ss=0",
                           if8.next_sel, if8.busy, if8.slot_start, IDLE8);
    end
    if8.open_streams = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (if8.next_sel == IDLE8 && !if8.busy) idle_ok++;
    end
    checks++;
    if (idle_ok !== 5) begin
      failures++; $display("FAIL drop_stay_idle got=%0d want=5", idle_ok);
    end
    if8.bt_state = 1'b1;
    tick();
    checks++;
    if (if8.next_sel !== 4'd4 || if8.slot_start !== 1'b1 || if8.busy !== 1'b1) begin
      failures++; $display("FAIL drop_resume got=%0d ss=%b busy=%b want=4 ss=1 busy=1",
                           if8.next_sel, if8.slot_start, if8.busy);
    end
  endtask

  task automatic test_no_streams();
    int idle_ok = 0;
    if8.open_streams = 8'h00;
    tick();
    checks++;
    if (if8.next_sel !== IDLE8 || if8.busy !== 1'b0) begin
      failures++; $display("FAIL none_idle got=%b busy=%b want=%b busy=0", if8.next_sel, if8.busy, IDLE8);
    end
    for (int i = 0; i < 50; i++) begin
      tick();
      if (if8.next_sel == IDLE8 && !if8.busy && !if8.slot_start) idle_ok++;
    end
    checks++;
    if (idle_ok !== 50) begin
      failures++; $display("FAIL none_stay_idle got=%0d want=50", idle_ok);
    end
    if8.open_streams = 8'b0100_0000;
    tick();
    checks++;
    if (if8.next_sel !== 4'd6 || if8.slot_start !== 1'b1) begin
      failures++; $display("FAIL none_wake got=%0d ss=%b want=6 ss=1", if8.next_sel, if8.slot_start);
    end
  endtask

  task automatic test_wrap16();
    int k   = 0;
    int bad = 0;
    if16.open_streams = 16'hFFFF;
    if16.bt_state     = 1'b1;
    if16.tx_done      = 1'b0;
    tick();
    for (int i = 0; i < 68; i++) begin
      if (if16.next_sel >= 5'd16 && if16.next_sel != IDLE16) bad++;
      if (if16.slot_start) begin
        checks++;
        if (if16.next_sel !== 5'(k % 16) || i !== 4 * k) begin
          failures++; $display("FAIL wrap_slot k=%0d got=%0d at=%0d want=%0d at=%0d",
                               k, if16.next_sel, i, k % 16, 4 * k);
        end
        k++;
      end
      tick();
    end
    checks++;
    if (k !== 17) begin
      failures++; $display("FAIL wrap_count got=%0d want=17", k);
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL wrap_range got=%0d want=0", bad);
    end
  endtask

  task automatic test_early_release();
    int         len     = 0;
    int         exp_len;
    logic [4:0] cur;
`ifdef STREAM_RR_EARLY_RELEASE_EN
    exp_len = 3;
`else
    exp_len = 4;
`endif
    checks++;
    if (if16.slot_start !== 1'b1 || if16.next_sel !== 5'd1) begin
      failures++; $display("FAIL early_start got=%0d ss=%b want=1 ss=1", if16.next_sel, if16.slot_start);
    end
    cur = if16.next_sel;
    for (int i = 0; i < 8; i++) begin
      if16.tx_done = (i == 1);
      tick();
      len++;
      if (if16.slot_start) break;
    end
    if16.tx_done = 1'b0;
    checks++;
    if (len !== exp_len) begin
      failures++; $display("FAIL early_len got=%0d want=%0d", len, exp_len);
    end
    checks++;
    if (if16.next_sel !== cur + 5'd1) begin
      failures++; $display("FAIL early_next got=%0d want=%0d", if16.next_sel, cur + 5'd1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_single_stream();
    test_close_mid_slot();
    test_link_drop();
    test_no_streams();
    test_wrap16();
    test_early_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
